decoder_scan_ctrl: RTL
======================

Name: decoder_scan_ctrl

Overview:
- Upstream driver for the 2-to-4 enable decoder; generates its En, w1 and w0 inputs.
- Cycles a 2-bit index through 0..3 (or 3..0), holding each index active for a programmable dwell time.
- Inserts a blanking gap with En low between indices so a downstream 4-digit multiplexed display does not ghost.
- Signals completion of every full frame (all four indices visited).

Parameters:
- DWELL, 50000: clk cycles En is held high per index; legal range >= 1.
- BLANK, 100: clk cycles En is held low between indices; 0 means no gap.
- CNT_W, 16: timer width; must satisfy 2^CNT_W > max(DWELL, BLANK).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- run  input  1  level; 1 = scan continuously, 0 = stop.
- dir  input  1  0 = increment index, 1 = decrement index.
- step_req  input  1  one-cycle pulse; single-step request (effective only with the optional feature).
- en  output  1  decoder enable, registered.
- w1  output  1  index MSB, registered.
- w0  output  1  index LSB, registered.
- frame_done  output  1  one-cycle pulse on index wrap.
- busy  output  1  high when the FSM is not in IDLE.

Interface (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: state=IDLE, idx=0, timer=0, en=0, w1=0, w0=0, frame_done=0, busy=0.
- All outputs are registered; {w1,w0} = idx at all times.
- FSM states: IDLE, ACTIVE, BLANK.
- IDLE, run=1: next cycle go to ACTIVE, load timer with DWELL-1, en=1; idx unchanged.
- ACTIVE: en=1; timer decrements each cycle. At timer==0:
  - BLANK>0: go to BLANK, load timer with BLANK-1, en=0.
  - BLANK==0: advance idx, reload timer with DWELL-1, stay in ACTIVE, en stays 1.
- BLANK: en=0. At timer==0: advance idx, go to ACTIVE, load timer with DWELL-1, en=1.
- Index advance:
  - idx +1 when dir=0, -1 when dir=1, modulo 4.
  - dir is sampled only on the advance cycle.
- frame_done: high for exactly the cycle in which the new idx is registered, when the advance wraps 3->0 (dir=0) or 0->3 (dir=1).
- en and {w1,w0} never change on the same edge with en=1 both before and after, except when BLANK==0.
- run=0 in ACTIVE or BLANK: go to IDLE on the next edge, en=0, idx held, timer cleared, no advance, no frame_done.
- run re-asserted: resume at the held idx with a full DWELL.
- busy = (state != IDLE).
- Asynchronous reset mid-dwell or mid-blank forces the reset values immediately.

Optional Feature:
- Macro: DECODER_SCAN_STEP_EN.
- Defined: in IDLE with run=0, a step_req pulse runs exactly one ACTIVE dwell on the current idx, then BLANK (if BLANK>0), advances idx (frame_done on wrap as normal), and returns to IDLE.
  - step_req while busy is ignored.
  - run=1 overrides: the scan continues normally.
- Undefined: step_req is ignored and has no logic behind it; the port stays present.

Decomposition:
- Shared package decoder_pkg:
  - state enum {IDLE, ACTIVE, BLANK}.
  - 2-bit index typedef.
  - constants IDX_MAX=3 and IDX_MIN=0.
- One sub-module: scan_timer (CNT_W-bit loadable down-counter with load, value, and zero flag), instantiated once and reused for both dwell and blank.

Test Plan (DWELL=4, BLANK=2 unless stated):
- Reset, then run=1, dir=0:
  - en high 4 cycles, low 2 cycles, repeating.
  - {w1,w0} sequence 0,1,2,3,0.
  - frame_done pulses once at the 3->0 advance, period 24 cycles.
- run=1, dir=1 from idx=0: sequence 0,3,2,1,0; frame_done at the 0->3 advance.
- BLANK=0: en continuously high after start; idx changes every 4 cycles; no en low gaps.
- Deassert run on the 2nd ACTIVE cycle of idx=2:
  - en=0 and busy=0 next cycle; idx stays 2.
  - After re-asserting run, idx=2 is active for a full 4 cycles.
- Assert rst during BLANK with idx=3: immediately en=0, idx=0, frame_done=0, state IDLE.
- With DECODER_SCAN_STEP_EN defined, run=0, three step_req pulses spaced 10 cycles apart:
  - each pulse produces one 4-cycle en burst; idx goes 0->1->2->3.
  - A step_req issued while busy causes no extra burst.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types for the 2-to-4 decoder scan controller: FSM states, index type
// and index stepping helpers.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_e;

  typedef logic [1:0] idx_t;

  localparam idx_t IDX_MAX = 2'd3;
  localparam idx_t IDX_MIN = 2'd0;

  function automatic idx_t next_idx(input idx_t idx, input logic dir);
    return dir ? idx - 2'd1 : idx + 2'd1;
  endfunction

  // A wrap is the step that leaves the last index in the current direction.
  function automatic logic is_wrap(input idx_t idx, input logic dir);
    return dir ? (idx == IDX_MIN) : (idx == IDX_MAX);
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_scan_timer.sv
// Loadable down-counter shared by the dwell and blanking phases; it holds at
// zero until reloaded.
module scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving En/w1/w0 of a 2-to-4 decoder with dwell and blanking.
// Defining DECODER_SCAN_STEP_EN adds single-step operation via step_req.
module decoder_scan_ctrl #(
  parameter int DWELL = 50000,
  parameter int BLANK = 100,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic dir,
  input  logic step_req,
  output logic en,
  output logic w1,
  output logic w0,
  output logic frame_done,
  output logic busy
);

  import decoder_pkg::*;

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  state_e           state_q, state_d;
  idx_t             idx_q, idx_d;
  logic             en_q, en_d;
  logic             fd_q, fd_d;
  logic             busy_q, busy_d;
  logic             tmrLoad, tmrClear, tmrZero;
  logic [CNT_W-1:0] tmrLoadVal;
  logic [CNT_W-1:0] unusedTmrValue;
  logic             stepStart, stepActive, abortScan, endStep;

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmrLoad),
    .clear_i    (tmrClear),
    .load_val_i (tmrLoadVal),
    .value_o    (unusedTmrValue),
    .zero_o     (tmrZero)
  );

`ifdef DECODER_SCAN_STEP_EN
  logic step_q, step_d;
  // A step survives run=0 until its slot ends; run=1 turns it into a normal scan.
  assign stepStart  = !run && step_req;
  assign step_d     = (state_q == decoder_pkg::IDLE) ? stepStart
                                                     : (step_q && !run && (state_d != decoder_pkg::IDLE));
  assign stepActive = step_q;
`else
  logic unusedStepReq;
  assign unusedStepReq = step_req;
  assign stepStart     = 1'b0;
  assign stepActive    = 1'b0;
`endif

  assign abortScan = !run && !stepActive;
  assign endStep   = stepActive && !run;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    en_d       = en_q;
    fd_d       = 1'b0;
    tmrLoad    = 1'b0;
    tmrClear   = 1'b0;
    tmrLoadVal = DWELL_LD;
    unique case (state_q)
      decoder_pkg::IDLE: begin
        if (run || stepStart) begin
          state_d = decoder_pkg::ACTIVE;
          en_d    = 1'b1;
          tmrLoad = 1'b1;
        end
      end
      decoder_pkg::ACTIVE, decoder_pkg::BLANK: begin
        if (abortScan) begin
          state_d  = decoder_pkg::IDLE;
          en_d     = 1'b0;
          tmrClear = 1'b1;
        end else if (tmrZero) begin
          if ((state_q == decoder_pkg::ACTIVE) && (BLANK > 0)) begin
            state_d    = decoder_pkg::BLANK;
            en_d       = 1'b0;
            tmrLoad    = 1'b1;
            tmrLoadVal = BLANK_LD;
          end else begin
            idx_d = next_idx(idx_q, dir);
            fd_d  = is_wrap(idx_q, dir);
            if (endStep) begin
              state_d = decoder_pkg::IDLE;
              en_d    = 1'b0;
            end else begin
              state_d = decoder_pkg::ACTIVE;
              en_d    = 1'b1;
              tmrLoad = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = decoder_pkg::IDLE;
        en_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != decoder_pkg::IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= decoder_pkg::IDLE;
      idx_q   <= IDX_MIN;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DECODER_SCAN_STEP_EN
      step_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
`ifdef DECODER_SCAN_STEP_EN
      step_q  <= step_d;
`endif
    end
  end

  assign en         = en_q;
  assign w1         = idx_q[1];
  assign w0         = idx_q[0];
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule
